// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Definitions shared by the pipeline stall/flush controller and its hazard
// detector.
//   ctrl_state_t    : controller state (RUN / DIV_WAIT)
//   REG_ZERO        : register number of $zero, which never carries a hazard
//   DIV_LAT_DEFAULT : default number of cycles a DIV occupies EX
//   CNT_W_DEFAULT   : default width of the stall-cycle counter
//   srcMatches()    : true when a source register really depends on a
//                     destination register (same number and not $zero)
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DIV_LAT_DEFAULT = 4;
    localparam int         CNT_W_DEFAULT   = 16;

    // $zero is hardwired, so a read of it can never depend on a load.
    function automatic logic srcMatches(input logic [4:0] src,
                                        input logic [4:0] dst);
        return (src == dst) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard compare. It says nothing about whether
// a stall is actually taken; the controller applies state and priority.
//   memread_i : instruction in EX is a load
//   id_rs_i   : rs field of the instruction in ID
//   id_rt_i   : rt field of the instruction in ID
//   ex_rt_i   : destination (rt) of the load in EX
//   hazard    : ID reads the register the load in EX is about to write
// ---------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       memread_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic [4:0] ex_rt_i,
    output logic       hazard
);

    logic w_rsMatch;
    logic w_rtMatch;

    assign w_rsMatch = srcMatches(id_rs_i, ex_rt_i);
    assign w_rtMatch = srcMatches(id_rt_i, ex_rt_i);
    assign hazard    = memread_i && (w_rsMatch || w_rtMatch);

endmodule

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage pipeline. Detects load-use
// hazards, squashes wrong-path instructions when a branch resolves taken in
// EX, freezes the front end while a multi-cycle DIV occupies EX, and keeps a
// saturating count of cycles in which the PC was held.
//
// Parameters
//   DIV_LAT : cycles a DIV occupies EX (legal range 2..255)
//   CNT_W   : width of the stall-cycle counter
// Ports
//   clk_i             : clock, all state updates on the rising edge
//   rst_i             : synchronous active-low reset
//   id_rs_i, id_rt_i  : source register fields of the instruction in ID
//   ex_rt_i           : load destination of the instruction in EX
//   ex_memread_i      : instruction in EX is a load
//   ex_branch_taken_i : branch in EX resolved taken this cycle
//   ex_div_start_i    : first cycle of a DIV in EX
//   pc_write_o        : PC update enable
//   if_id_write_o     : IF/ID write enable
//   id_ex_write_o     : ID/EX write enable
//   if_id_flush_o     : zero IF/ID on the next edge
//   id_ex_flush_o     : load an all-zero-control bubble into ID/EX
//   ex_mem_bubble_o   : load a bubble into EX/MEM
//   div_busy_o        : controller is in DIV_WAIT
//   div_done_o        : last EX cycle of the DIV
//   stall_cnt_o       : saturating count of cycles with pc_write_o low
// ---------------------------------------------------------------------------
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_memread_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_div_start_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_bubble_o,
    output logic             div_busy_o,
    output logic             div_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // The DIV start cycle itself is one stall, so DIV_WAIT begins with
    // DIV_LAT-2 further stall cycles still to go before the done cycle.
    localparam logic [7:0]       DIV_CNT_INIT = 8'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] STALL_MAX    = {CNT_W{1'b1}};

    ctrl_state_t      r_state;
    logic [7:0]       r_cnt;
    logic [CNT_W-1:0] r_stallCnt;

    logic w_hazard;
    logic w_pcWrite;
    logic w_ifIdWrite;
    logic w_idExWrite;
    logic w_ifIdFlush;
    logic w_idExFlush;
    logic w_exMemBubble;
    logic w_divBusy;
    logic w_divDone;
    logic w_divStartTaken;

    load_use_detect u_loadUse (
        .memread_i (ex_memread_i),
        .id_rs_i   (id_rs_i),
        .id_rt_i   (id_rt_i),
        .ex_rt_i   (ex_rt_i),
        .hazard    (w_hazard)
    );

    // A taken branch squashes the DIV sitting in EX, so a start only counts
    // when no branch resolves in the same cycle.
    assign w_divStartTaken = ex_div_start_i && !ex_branch_taken_i;

    // Control outputs are combinational so that hazard and branch responses
    // land in the same cycle as their inputs. While reset is held everything
    // is forced to the pass-through defaults regardless of the state register.
    always_comb begin
        w_pcWrite     = 1'b1;
        w_ifIdWrite   = 1'b1;
        w_idExWrite   = 1'b1;
        w_ifIdFlush   = 1'b0;
        w_idExFlush   = 1'b0;
        w_exMemBubble = 1'b0;
        w_divBusy     = 1'b0;
        w_divDone     = 1'b0;
        if (rst_i) begin
            unique case (r_state)
                RUN: begin
                    if (ex_branch_taken_i) begin
                        w_ifIdFlush = 1'b1;
                        w_idExFlush = 1'b1;
                    end else if (ex_div_start_i) begin
                        w_pcWrite     = 1'b0;
                        w_ifIdWrite   = 1'b0;
                        w_idExWrite   = 1'b0;
                        w_exMemBubble = 1'b1;
                    end else if (w_hazard) begin
                        // Hold PC and IF/ID, let ID/EX take a bubble: exactly
                        // one bubble, since the load moves on next cycle.
                        w_pcWrite   = 1'b0;
                        w_ifIdWrite = 1'b0;
                        w_idExFlush = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    w_divBusy = 1'b1;
                    if (r_cnt != 8'd0) begin
                        w_pcWrite     = 1'b0;
                        w_ifIdWrite   = 1'b0;
                        w_idExWrite   = 1'b0;
                        w_exMemBubble = 1'b1;
                    end else begin
                        w_divDone = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and DIV down-counter. Branch, DIV start and load-use inputs are
    // all ignored while waiting; only reset can cut a DIV short.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= RUN;
            r_cnt   <= 8'd0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_divStartTaken) begin
                        r_state <= DIV_WAIT;
                        r_cnt   <= DIV_CNT_INIT;
                    end
                end
                DIV_WAIT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Performance counter: one count per cycle in which the PC was held,
    // sticking at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stallCnt <= '0;
        end else if (!w_pcWrite && (r_stallCnt != STALL_MAX)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign pc_write_o      = w_pcWrite;
    assign if_id_write_o   = w_ifIdWrite;
    assign id_ex_write_o   = w_idExWrite;
    assign if_id_flush_o   = w_ifIdFlush;
    assign id_ex_flush_o   = w_idExFlush;
    assign ex_mem_bubble_o = w_exMemBubble;
    assign div_busy_o      = w_divBusy;
    assign div_done_o      = w_divDone;
    // The count reads zero as soon as reset is asserted, not one edge later.
    assign stall_cnt_o     = rst_i ? r_stallCnt : '0;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Drives two controller instances with the same inputs: instance A uses
// DIV_LAT=4 / CNT_W=16, instance B uses DIV_LAT=2 / CNT_W=4 so that the
// shortest DIV and counter saturation are both exercised. Expected values
// come from a cycle-level behavioural model of the controller's rules.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic [4:0] exRt;
    logic       exMemread;
    logic       exBranch;
    logic       exDivStart;

    logic        pcA, ifIdWA, idExWA, ifIdFlA, idExFlA, bubA, busyA, doneA;
    logic [15:0] cntA;
    logic        pcB, ifIdWB, idExWB, ifIdFlB, idExFlB, bubB, busyB, doneB;
    logic [3:0]  cntB;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state, index 0 = instance A, 1 = instance B.
    int divLat[2] = '{4, 2};
    int cntMax[2] = '{65535, 15};
    bit inDiv[2];
    int divCycle[2];
    int stallCnt[2];

    pipeline_stall_controller #(.DIV_LAT(4), .CNT_W(16)) dutA (
        .clk_i             (clk),
        .rst_i             (rstN),
        .id_rs_i           (idRs),
        .id_rt_i           (idRt),
        .ex_rt_i           (exRt),
        .ex_memread_i      (exMemread),
        .ex_branch_taken_i (exBranch),
        .ex_div_start_i    (exDivStart),
        .pc_write_o        (pcA),
        .if_id_write_o     (ifIdWA),
        .id_ex_write_o     (idExWA),
        .if_id_flush_o     (ifIdFlA),
        .id_ex_flush_o     (idExFlA),
        .ex_mem_bubble_o   (bubA),
        .div_busy_o        (busyA),
        .div_done_o        (doneA),
        .stall_cnt_o       (cntA)
    );

    pipeline_stall_controller #(.DIV_LAT(2), .CNT_W(4)) dutB (
        .clk_i             (clk),
        .rst_i             (rstN),
        .id_rs_i           (idRs),
        .id_rt_i           (idRt),
        .ex_rt_i           (exRt),
        .ex_memread_i      (exMemread),
        .ex_branch_taken_i (exBranch),
        .ex_div_start_i    (exDivStart),
        .pc_write_o        (pcB),
        .if_id_write_o     (ifIdWB),
        .id_ex_write_o     (idExWB),
        .if_id_flush_o     (ifIdFlB),
        .id_ex_flush_o     (idExFlB),
        .ex_mem_bubble_o   (bubB),
        .div_busy_o        (busyB),
        .div_done_o        (doneB),
        .stall_cnt_o       (cntB)
    );

    // One comparison: counts it, and on mismatch counts a failure and reports.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected flag vector {pc,ifIdW,idExW,ifIdFlush,idExFlush,bubble,busy,done}
    // for instance k given the model state and the current inputs.
    function automatic logic [7:0] expectedFlags(input int k);
        logic loadUse;
        loadUse = exMemread && (((idRs == exRt) && (idRs != 5'd0)) ||
                                ((idRt == exRt) && (idRt != 5'd0)));
        if (!rstN)                     return 8'b111_00_0_0_0;
        if (inDiv[k]) begin
            if (divCycle[k] < divLat[k] - 1) return 8'b000_00_1_1_0;
            return 8'b111_00_0_1_1;
        end
        if (exBranch)                  return 8'b111_11_0_0_0;
        if (exDivStart)                return 8'b000_00_1_0_0;
        if (loadUse)                   return 8'b001_01_0_0_0;
        return 8'b111_00_0_0_0;
    endfunction

    // Apply one cycle of inputs, check both instances mid-cycle, then advance
    // the model across the rising edge.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] ert, input logic mr,
                                 input logic br, input logic ds,
                                 input logic rst, input string tag);
        logic [7:0] expFlags[2];
        logic [7:0] obsFlags[2];
        idRs = rs; idRt = rt; exRt = ert;
        exMemread = mr; exBranch = br; exDivStart = ds; rstN = rst;
        @(negedge clk);
        for (int k = 0; k < 2; k++) expFlags[k] = expectedFlags(k);
        obsFlags[0] = {pcA, ifIdWA, idExWA, ifIdFlA, idExFlA, bubA, busyA, doneA};
        obsFlags[1] = {pcB, ifIdWB, idExWB, ifIdFlB, idExFlB, bubB, busyB, doneB};
        checkOutput({tag, "/A.flags"}, {8'd0, obsFlags[0]}, {8'd0, expFlags[0]});
        checkOutput({tag, "/B.flags"}, {8'd0, obsFlags[1]}, {8'd0, expFlags[1]});
        checkOutput({tag, "/A.cnt"}, cntA, rstN ? 16'(stallCnt[0]) : 16'd0);
        checkOutput({tag, "/B.cnt"}, {12'd0, cntB}, rstN ? 16'(stallCnt[1]) : 16'd0);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rstN) begin
                inDiv[k] = 1'b0;
                stallCnt[k] = 0;
            end else begin
                if (!expFlags[k][7] && stallCnt[k] < cntMax[k]) stallCnt[k]++;
                if (inDiv[k]) begin
                    if (divCycle[k] >= divLat[k] - 1) inDiv[k] = 1'b0;
                    else divCycle[k]++;
                end else if (exDivStart && !exBranch) begin
                    inDiv[k] = 1'b1;
                    divCycle[k] = 1;
                end
            end
        end
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            inDiv[k] = 1'b0; divCycle[k] = 0; stallCnt[k] = 0;
        end
        idRs = '0; idRt = '0; exRt = '0;
        exMemread = 1'b0; exBranch = 1'b0; exDivStart = 1'b0; rstN = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, "reset0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "reset1");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "idle");

        // Load-use on rs, then $zero immunity, then branch beating load-use.
        applyStimulus(5, 2, 5, 1, 0, 0, 1, "loadUseRs");
        applyStimulus(7, 9, 9, 1, 0, 0, 1, "loadUseRt");
        applyStimulus(3, 0, 0, 1, 0, 0, 1, "zeroImmune");
        applyStimulus(5, 0, 5, 0, 0, 0, 1, "noLoad");
        applyStimulus(5, 0, 5, 1, 1, 0, 1, "branchOverLoad");
        applyStimulus(5, 0, 5, 1, 1, 1, 1, "branchOverDiv");

        // DIV with a branch pulse in its second cycle.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, "div0");
        applyStimulus(5, 0, 5, 1, 1, 0, 1, "div1");
        applyStimulus(0, 0, 0, 0, 0, 1, 1, "div2");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "div3");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "div4");

        // Reset in the middle of a DIV, then a fresh load-use.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, "rdiv0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "rdiv1");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "rdiv2");
        applyStimulus(4, 0, 4, 1, 0, 0, 1, "rdivLoad");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "rdivIdle");

        // Long run of load-use cycles drives instance B into saturation.
        for (int i = 0; i < 20; i++)
            applyStimulus(6, 6, 6, 1, 0, 0, 1, $sformatf("sat%0d", i));

        // Randomized traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 400; i++)
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 39) != 0), $sformatf("rand%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
